// File: rtl/usrt_pkg.sv
// Shared USRT package: byte width and default TX FIFO depth, used by the
// serializer, data register and TX FIFO.
package usrt_pkg;

    localparam int unsigned USRT_DATA_W            = 8;
    localparam int unsigned USRT_TX_FIFO_DEPTH_DEF = 8;

    typedef logic [USRT_DATA_W-1:0] usrt_byte_t;

endpackage

// File: rtl/usrt_tx_fifo_if.sv
// Push/pop and status bundle of the USRT TX FIFO.
// almost_full exists only when USRT_TX_FIFO_ALMOST_FULL_EN is defined.
interface usrt_tx_fifo_if
    import usrt_pkg::*;
#(
    parameter int unsigned DEPTH = USRT_TX_FIFO_DEPTH_DEF
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    usrt_byte_t       wr_data;
    logic             tx_ready;
    logic             tx_valid;
    usrt_byte_t       tx_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             clr_ovf;
    logic             overflow;
`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
    logic             almost_full;
`endif

    // APB write path and serializer side
    modport master (
        output wr_en, wr_data, tx_ready, clr_ovf,
`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
        input  almost_full,
`endif
        input  tx_valid, tx_data, full, empty, count, overflow
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, tx_ready, clr_ovf,
`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
        output almost_full,
`endif
        output tx_valid, tx_data, full, empty, count, overflow
    );

endinterface

// File: rtl/usrt_tx_fifo.sv
// Show-ahead byte FIFO from the APB write path to the USRT serializer.
// Define USRT_TX_FIFO_ALMOST_FULL_EN to add the almost_full status output.
module usrt_tx_fifo
    import usrt_pkg::*;
#(
    parameter int unsigned DEPTH    = USRT_TX_FIFO_DEPTH_DEF
`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
   ,parameter int unsigned AF_LEVEL = DEPTH - 2
`endif
) (
    input logic            pClk,
    input logic            uRst,
    usrt_tx_fifo_if.slave  fifo
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    usrt_byte_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    always_comb begin
        empty_c = (count_q == CNT_W'(0));
        full_c  = (count_q == CNT_W'(DEPTH));
        pop_c   = !empty_c && fifo.tx_ready;
        push_c  = fifo.wr_en && (!full_c || pop_c);
        drop_c  = fifo.wr_en && full_c && !pop_c;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge pClk) begin
        if (uRst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
            else if (pop_c && !push_c) count_q <= count_q - CNT_W'(1);
            if (drop_c)            ovf_q <= 1'b1;
            else if (fifo.clr_ovf) ovf_q <= 1'b0;
        end
    end

    // Storage is not reset; stale entries are never visible past rd_ptr/count
    always_ff @(posedge pClk) begin
        if (push_c && !uRst) mem[wr_ptr] <= fifo.wr_data;
    end

    assign fifo.tx_valid = !empty_c;
    assign fifo.tx_data  = empty_c ? USRT_DATA_W'(0) : mem[rd_ptr];
    assign fifo.full     = full_c;
    assign fifo.empty    = empty_c;
    assign fifo.count    = count_q;
    assign fifo.overflow = ovf_q;
`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
    assign fifo.almost_full = (count_q >= CNT_W'(AF_LEVEL));
`endif

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Scoreboard bench for usrt_tx_fifo at DEPTH 8: every accepted push is queued,
// every pop is compared against the queue head.
module tb_usrt_tx_fifo;

    localparam int unsigned DEPTH = 8;

    logic pClk;
    logic uRst;
    int   checks;
    int   errors;

    logic [7:0] exp_q [$];
    logic       exp_ovf;

    usrt_tx_fifo_if #(.DEPTH(DEPTH)) fifo_if ();

    usrt_tx_fifo #(.DEPTH(DEPTH)) dut (
        .pClk (pClk),
        .uRst (uRst),
        .fifo (fifo_if.slave)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    // One clock of stimulus; a pop is checked against the scoreboard head
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
        bit was_full;
        bit do_pop;
        bit do_push;
        was_full = (exp_q.size() == DEPTH);
        do_pop   = rdy && (exp_q.size() != 0);
        do_push  = wr && (!was_full || do_pop);
        fifo_if.wr_en    = wr;
        fifo_if.wr_data  = d;
        fifo_if.tx_ready = rdy;
        fifo_if.clr_ovf  = clr;
        if (do_pop) begin
            checks++;
            if (fifo_if.tx_valid !== 1'b1 || fifo_if.tx_data !== exp_q[0]) begin
                errors++;
                $display("FAIL pop_data: got valid=%b data=%02h, expected valid=1 data=%02h",
                         fifo_if.tx_valid, fifo_if.tx_data, exp_q[0]);
            end
        end
        @(posedge pClk);
        #1;
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        if (wr && !do_push) exp_ovf = 1'b1;
        else if (clr)       exp_ovf = 1'b0;
        fifo_if.wr_en    = 1'b0;
        fifo_if.tx_ready = 1'b0;
        fifo_if.clr_ovf  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (fifo_if.empty !== 1'b1 || fifo_if.tx_data !== 8'h00 || fifo_if.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got empty=%b valid=%b data=%02h, expected 1 0 00",
                     fifo_if.empty, fifo_if.tx_valid, fifo_if.tx_data);
        end
    endtask

    task automatic test_reset();
        uRst = 1'b1;
        repeat (2) @(posedge pClk);
        #1;
        uRst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        checks++;
        if (fifo_if.empty !== 1'b1 || fifo_if.full !== 1'b0 || fifo_if.count !== 4'd0 ||
            fifo_if.tx_valid !== 1'b0 || fifo_if.tx_data !== 8'h00 || fifo_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got empty=%b full=%b count=%0d valid=%b data=%02h ovf=%b, expected 1 0 0 0 00 0",
                     fifo_if.empty, fifo_if.full, fifo_if.count, fifo_if.tx_valid, fifo_if.tx_data, fifo_if.overflow);
        end
    endtask

    task automatic test_basic();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (fifo_if.tx_valid !== 1'b1 || fifo_if.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_latency: got valid=%b data=%02h, expected 1 a5", fifo_if.tx_valid, fifo_if.tx_data);
        end
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b1, 8'h0F, 1'b0, 1'b0);
        checks++;
        if (fifo_if.count !== 4'd3 || fifo_if.tx_data !== 8'hA5 || fifo_if.empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_fill: got count=%0d data=%02h empty=%b, expected 3 a5 0",
                     fifo_if.count, fifo_if.tx_data, fifo_if.empty);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (fifo_if.full !== 1'b1 || fifo_if.overflow !== 1'b1 || fifo_if.count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set: got full=%b ovf=%b count=%0d, expected 1 1 8",
                     fifo_if.full, fifo_if.overflow, fifo_if.count);
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++;
        if (fifo_if.overflow !== 1'b1 || fifo_if.count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set_wins: got ovf=%b count=%0d, expected 1 8", fifo_if.overflow, fifo_if.count);
        end
        drain();
        checks++;
        if (fifo_if.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got ovf=%b, expected 1", fifo_if.overflow);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (fifo_if.overflow !== 1'b0 || exp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b, expected 0", fifo_if.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (fifo_if.overflow !== 1'b0 || fifo_if.count !== 4'd8 || fifo_if.tx_data !== 8'h01) begin
            errors++;
            $display("FAIL full_push_pop: got ovf=%b count=%0d head=%02h, expected 0 8 01",
                     fifo_if.overflow, fifo_if.count, fifo_if.tx_data);
        end
        checks++;
        if (exp_q.size() != DEPTH || exp_q[DEPTH-1] !== 8'h55) begin
            errors++;
            $display("FAIL full_push_pop_model: got size=%0d, expected 8 with 55 last", exp_q.size());
        end
        drain();
    endtask

    task automatic test_empty_push_pop();
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        checks++;
        if (fifo_if.tx_valid !== 1'b1 || fifo_if.tx_data !== 8'h99 || fifo_if.count !== 4'd1) begin
            errors++;
            $display("FAIL empty_push_pop: got valid=%b data=%02h count=%0d, expected 1 99 1",
                     fifo_if.tx_valid, fifo_if.tx_data, fifo_if.count);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        b = 8'h40;
        cycle(1'b1, b, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            b = b + 8'd1;
            cycle(1'b1, b, 1'b1, 1'b0);
            checks++;
            if (fifo_if.count !== 4'd1 || fifo_if.full !== 1'b0) begin
                errors++;
                $display("FAIL wrap_count: iter %0d got count=%0d full=%b, expected 1 0", i, fifo_if.count, fifo_if.full);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (fifo_if.count !== 4'd5 || fifo_if.overflow !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got count=%0d ovf=%b, expected 5 1", fifo_if.count, fifo_if.overflow);
        end
        uRst = 1'b1;
        fifo_if.wr_en   = 1'b1;
        fifo_if.wr_data = 8'h77;
        fifo_if.tx_ready = 1'b1;
        @(posedge pClk);
        #1;
        uRst = 1'b0;
        fifo_if.wr_en    = 1'b0;
        fifo_if.tx_ready = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        checks++;
        if (fifo_if.count !== 4'd0 || fifo_if.empty !== 1'b1 || fifo_if.overflow !== 1'b0 ||
            fifo_if.tx_valid !== 1'b0 || fifo_if.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d empty=%b ovf=%b valid=%b data=%02h, expected 0 1 0 0 00",
                     fifo_if.count, fifo_if.empty, fifo_if.overflow, fifo_if.tx_valid, fifo_if.tx_data);
        end
    endtask

`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        checks++;
        if (fifo_if.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL af_at_5: got %b, expected 0", fifo_if.almost_full);
        end
        cycle(1'b1, 8'hC5, 1'b0, 1'b0);
        checks++;
        if (fifo_if.almost_full !== 1'b1) begin
            errors++;
            $display("FAIL af_at_6: got %b, expected 1", fifo_if.almost_full);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (fifo_if.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL af_back_5: got %b, expected 0", fifo_if.almost_full);
        end
        drain();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        exp_ovf = 1'b0;
        uRst = 1'b1;
        fifo_if.wr_en    = 1'b0;
        fifo_if.wr_data  = 8'h00;
        fifo_if.tx_ready = 1'b0;
        fifo_if.clr_ovf  = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_reset_mid();
`ifdef USRT_TX_FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usrt_tx_fifo.md
# usrt_tx_fifo

Byte FIFO between the APB write path and the USRT serializer. Accepts one byte per write strobe from the APB enable logic (wEn qualified), buffers up to DEPTH bytes, and presents the oldest byte to the serializer through a valid/ready handshake, one byte per frame. Provides full/empty/count status and a sticky overflow flag for APB status readback.

## Interface
- DEPTH, 8: number of byte entries; power of two, 2..64.
- AF_LEVEL, DEPTH-2: almost-full threshold; 1..DEPTH-1. Only used with the macro in Configuration.

- pClk  in  1  single clock for the block; all state updates on posedge.
- uRst  in  1  synchronous, active-high reset.
- wr_en  in  1  push strobe, one byte per high cycle.
- wr_data  in  8  byte to push.
- tx_ready  in  1  serializer accepts the head byte (frame start).
- tx_valid  out  1  head byte available (= !empty).
- tx_data  out  8  head byte; 8'h00 when empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- clr_ovf  in  1  clears overflow.
- overflow  out  1  sticky: a push was dropped.
- almost_full  out  1  count >= AF_LEVEL (macro only).

## Operation
- Storage: DEPTH x 8 register array; wr_ptr, rd_ptr each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; count tracked separately (DEPTH+1 states).
- Show-ahead read: tx_data = mem[rd_ptr] when !empty, else 8'h00.
- pop = tx_valid & tx_ready. push = wr_en & (!full | pop).
- push only: mem[wr_ptr] <= wr_data, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push & pop: both pointers advance, count unchanged; legal when full (freed slot reused same cycle).
- Empty with wr_en and tx_ready high: no pop (tx_valid low); push proceeds.
- wr_en while full with no pop: byte dropped, pointers/count unchanged, overflow <= 1.
- overflow: set by a dropped push, cleared by clr_ovf; same-cycle set and clear -> set wins.
- tx_ready while empty: ignored, no underflow state.
- Reset: wr_ptr=0, rd_ptr=0, count=0, overflow=0 -> empty=1, full=0, tx_valid=0, tx_data=8'h00, almost_full=0. Memory contents not reset. Reset mid-operation discards all buffered bytes; reset overrides push, pop and clr_ovf in the same cycle.

## Timing
- Write-to-valid latency: 1 cycle (push at edge N, tx_valid and tx_data valid after edge N).
- Pop takes effect at the edge where tx_valid & tx_ready; next head visible immediately after that edge.
- full, empty, count, almost_full: registered-state decodes, update the cycle after the causing edge; no combinational path from wr_en to any output. tx_ready -> push acceptance (when full) is combinational inside the block only.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- USRT_TX_FIFO_ALMOST_FULL_EN defined: almost_full port and AF_LEVEL compare present.
- Not defined: almost_full port absent, AF_LEVEL unused; all other behaviour identical.

## Structure
- Shared package usrt_pkg: USRT_DATA_W = 8, USRT_TX_FIFO_DEPTH_DEF = 8, also used by serializer and data_reg.
- Single module, no sub-module; pointer/count logic and array small enough inline.

## Test plan
- Reset then 3 pushes 8'hA5, 8'h3C, 8'h0F with tx_ready=0 -> count=3, tx_data=8'hA5, empty=0; pop 3 times -> outputs A5, 3C, 0F in order, then empty=1, tx_data=8'h00.
- Fill DEPTH=8 with 8'h00..8'h07, 9th push 8'hFF -> full=1, overflow=1, count=8, drained sequence 00..07 (FF absent); clr_ovf -> overflow=0.
- Full FIFO, push 8'h55 with tx_ready=1 same cycle -> no overflow, count stays 8, 8'h55 emerges last after 01..07.
- Empty FIFO, wr_en=1 wr_data=8'h99 with tx_ready=1 -> no pop that cycle, next cycle tx_valid=1, tx_data=8'h99, count=1.
- Pointer wrap: 20 push/pop pairs of incrementing bytes at depth 8 -> output stream equals input stream, count never exceeds 2.
- uRst asserted with count=5 and overflow=1, same cycle wr_en=1 -> count=0, empty=1, overflow=0, tx_valid=0; with macro, almost_full reaches 1 at count=6 and clears at count=5.
